// File: rtl/owr_slave_pkg.sv
// Shared FSM state type, 1-wire command codes and timing helper for the slave emulator.
package owr_slave_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StRstLow,
        StPresWait,
        StPresDrive,
        StRxRom,
        StRxFunc,
        StTxRom,
        StTxData,
        StHalt
    } owr_state_e;

    localparam logic [7:0] CMD_READ_ROM     = 8'h33;
    localparam logic [7:0] CMD_SKIP_ROM     = 8'hCC;
    localparam logic [7:0] CMD_READ_SCRATCH = 8'hBE;

    function automatic int unsigned us2cyc(input int unsigned us, input int unsigned clk_per_us);
        return us * clk_per_us;
    endfunction

endpackage

// File: rtl/owr_slot_timer.sv
// Bus input conditioning for the 1-wire slave: synchronizer, edge detect,
// reset-pulse qualification and the per-slot timer.
module owr_slot_timer
    import owr_slave_pkg::*;
#(
    parameter int unsigned CLK_PER_US = 48,
    parameter int unsigned T_RST_MIN  = 400,
    parameter int unsigned T_SAMPLE   = 30,
    parameter int unsigned T_END      = 30
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_owr_in,
    input  logic i_drive,
    input  logic i_slot_en,
    output logic o_level,
    output logic o_fe,
    output logic o_re,
    output logic o_rst_det,
    output logic o_sample_tick,
    output logic o_slot_end
);

    localparam int unsigned SampleCyc = us2cyc(T_SAMPLE, CLK_PER_US);
    localparam int unsigned EndCyc    = us2cyc(T_END, CLK_PER_US);
    localparam int unsigned LastCyc   = (SampleCyc > EndCyc) ? SampleCyc : EndCyc;
    localparam logic [15:0] RstThr    = 16'(us2cyc(T_RST_MIN, CLK_PER_US) - 1);

    logic        r_meta;
    logic        r_sync;
    logic        r_prev;
    logic        r_fe;
    logic        r_re;
    logic [15:0] r_low;
    logic        r_rst_det;
    logic [15:0] r_slot;
    logic        r_run;

    logic w_low_cnt;
    logic w_start;
    logic w_last;

    // Our own pull-down must not count towards a reset pulse.
    assign w_low_cnt = ~r_sync & ~i_drive;
    assign w_start   = r_fe & i_slot_en & ~r_run;
    assign w_last    = r_run && (r_slot == 16'(LastCyc - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta    <= 1'b1;
            r_sync    <= 1'b1;
            r_prev    <= 1'b1;
            r_fe      <= 1'b0;
            r_re      <= 1'b0;
            r_low     <= 16'd0;
            r_rst_det <= 1'b0;
            r_slot    <= 16'd0;
            r_run     <= 1'b0;
        end else begin
            r_meta    <= i_owr_in;
            r_sync    <= r_meta;
            r_prev    <= r_sync;
            r_fe      <= r_prev & ~r_sync;
            r_re      <= ~r_prev & r_sync;
            r_rst_det <= w_low_cnt && (r_low == RstThr);

            if (r_sync) begin
                r_low <= 16'd0;
            end else if (w_low_cnt && (r_low != 16'hFFFF)) begin
                r_low <= r_low + 16'd1;
            end

            if (!i_slot_en) begin
                r_run  <= 1'b0;
                r_slot <= 16'd0;
            end else if (w_start) begin
                r_run  <= 1'b1;
                r_slot <= 16'd0;
            end else if (r_run) begin
                if (w_last) begin
                    r_run <= 1'b0;
                end
                if (r_slot != 16'hFFFF) begin
                    r_slot <= r_slot + 16'd1;
                end
            end
        end
    end

    // o_fe only reports falling edges that actually open a slot.
    assign o_level       = r_sync;
    assign o_fe          = w_start;
    assign o_re          = r_re;
    assign o_rst_det     = r_rst_det;
    assign o_sample_tick = r_run && (r_slot == 16'(SampleCyc - 1));
    assign o_slot_end    = r_run && (r_slot == 16'(EndCyc - 1));

endmodule

// File: rtl/owr_slave_emu.sv
// 1-wire slave emulating one DS18B20-style sensor: presence, READ ROM and
// SKIP ROM + READ SCRATCHPAD (2-byte temperature), standard speed.
module owr_slave_emu
    import owr_slave_pkg::*;
#(
    parameter int unsigned CLK_PER_US = 48,
    parameter logic [63:0] ROM_ID     = 64'h28_0000_0000_0001_28,
    parameter int unsigned T_RST_MIN  = 400,
    parameter int unsigned T_PDH      = 30,
    parameter int unsigned T_PDL      = 120,
    parameter int unsigned T_SAMPLE   = 30,
    parameter int unsigned T_TX0      = 30
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_owr_in,
    output logic        o_owr_out,
    input  logic [15:0] i_temp_data,
    output logic        o_cmd_valid,
    output logic [7:0]  o_cmd_byte,
    output logic        o_presence,
    output logic        o_busy
);

    // Release is seen three cycles late through the input path; shorten the wait to match.
    localparam int unsigned SyncLat = 3;
    localparam logic [15:0] PdhLast = 16'(us2cyc(T_PDH, CLK_PER_US) - SyncLat - 1);
    localparam logic [15:0] PdlLast = 16'(us2cyc(T_PDL, CLK_PER_US) - 1);

    owr_state_e  r_state;
    logic        r_owr_out;
    logic        r_cmd_valid;
    logic [7:0]  r_cmd_byte;
    logic        r_presence;
    logic        r_busy;
    logic [15:0] r_tmr;
    logic [6:0]  r_bit_cnt;
    logic [7:0]  r_rx;
    logic [63:0] r_tx;

    logic       w_level;
    logic       w_fe;
    logic       w_re;
    logic       w_rst_det;
    logic       w_sample_tick;
    logic       w_slot_end;
    logic       w_slot_en;
    logic [7:0] w_rx_next;

    assign w_slot_en = (r_state == StRxRom) || (r_state == StRxFunc) ||
                       (r_state == StTxRom) || (r_state == StTxData);
    assign w_rx_next = {w_level, r_rx[7:1]};

    owr_slot_timer #(
        .CLK_PER_US (CLK_PER_US),
        .T_RST_MIN  (T_RST_MIN),
        .T_SAMPLE   (T_SAMPLE),
        .T_END      (T_TX0)
    ) u_slot_timer (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_owr_in      (i_owr_in),
        .i_drive       (r_owr_out),
        .i_slot_en     (w_slot_en),
        .o_level       (w_level),
        .o_fe          (w_fe),
        .o_re          (w_re),
        .o_rst_det     (w_rst_det),
        .o_sample_tick (w_sample_tick),
        .o_slot_end    (w_slot_end)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_owr_out   <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_cmd_byte  <= 8'd0;
            r_presence  <= 1'b0;
            r_busy      <= 1'b0;
            r_tmr       <= 16'd0;
            r_bit_cnt   <= 7'd0;
            r_rx        <= 8'd0;
            r_tx        <= 64'd0;
        end else begin
            r_cmd_valid <= 1'b0;
            r_presence  <= 1'b0;
            if (w_rst_det) begin
                // Master reset overrides everything, including our own drive.
                r_state   <= StRstLow;
                r_owr_out <= 1'b0;
                r_busy    <= 1'b1;
                r_tmr     <= 16'd0;
                r_bit_cnt <= 7'd0;
                r_rx      <= 8'd0;
            end else begin
                unique case (r_state)
                    StIdle: begin
                        r_owr_out <= 1'b0;
                    end
                    StRstLow: begin
                        if (w_re) begin
                            r_state <= StPresWait;
                            r_tmr   <= 16'd0;
                        end
                    end
                    StPresWait: begin
                        if (r_tmr == PdhLast) begin
                            r_state    <= StPresDrive;
                            r_owr_out  <= 1'b1;
                            r_presence <= 1'b1;
                            r_tmr      <= 16'd0;
                        end else begin
                            r_tmr <= r_tmr + 16'd1;
                        end
                    end
                    StPresDrive: begin
                        if (r_tmr == PdlLast) begin
                            r_state   <= StRxRom;
                            r_owr_out <= 1'b0;
                            r_bit_cnt <= 7'd0;
                        end else begin
                            r_tmr <= r_tmr + 16'd1;
                        end
                    end
                    StRxRom, StRxFunc: begin
                        if (w_sample_tick) begin
                            r_rx <= w_rx_next;
                            if (r_bit_cnt == 7'd7) begin
                                r_bit_cnt   <= 7'd0;
                                r_cmd_byte  <= w_rx_next;
                                r_cmd_valid <= 1'b1;
                                if (r_state == StRxRom && w_rx_next == CMD_READ_ROM) begin
                                    r_state   <= StTxRom;
                                    r_tx      <= ROM_ID;
                                    r_bit_cnt <= 7'd64;
                                end else if (r_state == StRxRom && w_rx_next == CMD_SKIP_ROM) begin
                                    r_state <= StRxFunc;
                                end else if (r_state == StRxFunc &&
                                             w_rx_next == CMD_READ_SCRATCH) begin
                                    r_state   <= StTxData;
                                    r_tx      <= {48'd0, i_temp_data};
                                    r_bit_cnt <= 7'd16;
                                end else begin
                                    r_state <= StHalt;
                                    r_busy  <= 1'b0;
                                end
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 7'd1;
                            end
                        end
                    end
                    StTxRom, StTxData: begin
                        if (w_fe && !r_tx[0]) begin
                            r_owr_out <= 1'b1;
                        end
                        if (w_slot_end) begin
                            r_owr_out <= 1'b0;
                            r_tx      <= r_tx >> 1;
                            r_bit_cnt <= r_bit_cnt - 7'd1;
                            if (r_bit_cnt == 7'd1) begin
                                r_state <= StHalt;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                    StHalt: begin
                        r_owr_out <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                    default: begin
                        r_state   <= StIdle;
                        r_owr_out <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_owr_out   = r_owr_out;
    assign o_cmd_valid = r_cmd_valid;
    assign o_cmd_byte  = r_cmd_byte;
    assign o_presence  = r_presence;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_owr_slave_emu.sv
// Self-checking bench for owr_slave_emu: a bus master model drives reset,
// write and read slots on a wired-AND line; results are checked against the protocol rules.
module tb_owr_slave_emu;
    import owr_slave_pkg::*;

    localparam int unsigned CPU     = 4;
    localparam logic [63:0] ROM     = 64'h2800000000000128;
    localparam int unsigned PDH_CYC = 30 * CPU;
    localparam int unsigned PDL_CYC = 120 * CPU;
    localparam int unsigned TX0_CYC = 30 * CPU;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        master_low = 1'b0;
    logic [15:0] temp_data = 16'd0;
    logic        owr_out;
    logic        cmd_valid;
    logic [7:0]  cmd_byte;
    logic        presence;
    logic        busy;
    logic        owr_line;

    int n_pass  = 0;
    int n_total = 0;
    int n_pres  = 0;
    int n_cmd   = 0;
    logic [7:0] last_cmd = 8'd0;

    assign owr_line = ~(master_low | owr_out);

    always #5 clk = ~clk;

    owr_slave_emu #(
        .CLK_PER_US (CPU),
        .ROM_ID     (ROM)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_owr_in    (owr_line),
        .o_owr_out   (owr_out),
        .i_temp_data (temp_data),
        .o_cmd_valid (cmd_valid),
        .o_cmd_byte  (cmd_byte),
        .o_presence  (presence),
        .o_busy      (busy)
    );

    always @(negedge clk) begin
        if (presence === 1'b1) n_pres++;
        if (cmd_valid === 1'b1) begin
            n_cmd++;
            last_cmd = cmd_byte;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // 480 us reset pulse, then measure presence delay and width.
    task automatic do_reset(input string tag);
        int pres0;
        int t;
        int hi;
        pres0 = n_pres;
        master_low = 1'b1;
        cycles(480 * CPU);
        master_low = 1'b0;
        t = 0;
        while (owr_out !== 1'b1 && t < 2 * PDH_CYC) begin
            cycles(1);
            t++;
        end
        check({tag, "_pres_delay"}, 64'(t >= PDH_CYC - 4 && t <= PDH_CYC + 4), 64'd1);
        hi = 0;
        while (owr_out === 1'b1 && hi < 2 * PDL_CYC) begin
            cycles(1);
            hi++;
        end
        check({tag, "_pres_width"}, 64'(hi), 64'(PDL_CYC));
        check({tag, "_pres_pulse"}, 64'(n_pres - pres0), 64'd1);
        check({tag, "_state_rxrom"}, 64'(dut.r_state), 64'(StRxRom));
        check({tag, "_busy"}, 64'(busy), 64'd1);
        cycles(10 * CPU);
    endtask

    task automatic write_byte(input string tag, input logic [7:0] b);
        int c0;
        c0 = n_cmd;
        for (int i = 0; i < 8; i++) begin
            master_low = 1'b1;
            cycles(b[i] ? 6 * CPU : 60 * CPU);
            master_low = 1'b0;
            cycles(b[i] ? 64 * CPU : 10 * CPU);
            cycles(int'($urandom_range(1, 20)));
        end
        check({tag, "_cmd_pulse"}, 64'(n_cmd - c0), 64'd1);
        check({tag, "_cmd_byte"}, 64'(last_cmd), 64'(b));
    endtask

    task automatic read_slot(output int drv);
        drv = 0;
        master_low = 1'b1;
        for (int k = 0; k < 65 * CPU; k++) begin
            if (k == 2 * CPU) master_low = 1'b0;
            cycles(1);
            if (owr_out === 1'b1) drv++;
        end
        cycles(int'($urandom_range(1, 20)));
    endtask

    task automatic read_bits(input string tag, input logic [63:0] ref_word, input int n);
        int drv;
        for (int i = 0; i < n; i++) begin
            read_slot(drv);
            check($sformatf("%s_bit%0d", tag, i), 64'(drv),
                  ((ref_word >> i) & 64'd1) != 64'd0 ? 64'd0 : 64'(TX0_CYC));
        end
    endtask

    initial begin
        int pres0;
        int t;
        logic [15:0] temp_ref;

        // Reset values
        rst = 1'b1;
        cycles(5);
        check("rst_owr_out", 64'(owr_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
        check("rst_cmd_byte", 64'(cmd_byte), 64'd0);
        check("rst_presence", 64'(presence), 64'd0);
        rst = 1'b0;
        cycles(10);

        // Too-short low pulse must not qualify as reset
        pres0 = n_pres;
        master_low = 1'b1;
        cycles(300 * CPU);
        master_low = 1'b0;
        cycles(200 * CPU);
        check("short_no_presence", 64'(n_pres - pres0), 64'd0);
        check("short_busy", 64'(busy), 64'd0);
        check("short_state_idle", 64'(dut.r_state), 64'(StIdle));

        // READ ROM
        do_reset("rom");
        write_byte("rom", CMD_READ_ROM);
        read_bits("rom", ROM, 64);
        check("rom_state_halt", 64'(dut.r_state), 64'(StHalt));
        check("rom_busy_low", 64'(busy), 64'd0);

        // SKIP ROM + READ SCRATCHPAD, fixed then random temperature
        for (int pass = 0; pass < 2; pass++) begin
            temp_ref  = (pass == 0) ? 16'h0191 : 16'($urandom);
            temp_data = temp_ref;
            do_reset($sformatf("scr%0d", pass));
            write_byte($sformatf("scr%0d_skip", pass), CMD_SKIP_ROM);
            write_byte($sformatf("scr%0d_read", pass), CMD_READ_SCRATCH);
            temp_data = ~temp_ref;  // must have been captured at decode
            read_bits($sformatf("scr%0d", pass), 64'(temp_ref), 16);
            check($sformatf("scr%0d_state_halt", pass), 64'(dut.r_state), 64'(StHalt));
        end

        // Unknown ROM command halts and ignores slots
        do_reset("bad");
        write_byte("bad", 8'hF0);
        check("bad_state_halt", 64'(dut.r_state), 64'(StHalt));
        check("bad_busy_low", 64'(busy), 64'd0);
        read_bits("bad", 64'hFFFF_FFFF_FFFF_FFFF, 8);

        // Reset pulse in the middle of a ROM transfer
        do_reset("abort_pre");
        write_byte("abort", CMD_READ_ROM);
        read_bits("abort", ROM, 10);
        do_reset("abort_post");

        // Synchronous reset while driving presence
        master_low = 1'b1;
        cycles(480 * CPU);
        master_low = 1'b0;
        t = 0;
        while (owr_out !== 1'b1 && t < 4 * PDH_CYC) begin
            cycles(1);
            t++;
        end
        check("pd_rst_driving", 64'(owr_out), 64'd1);
        cycles(50);
        rst = 1'b1;
        cycles(1);
        check("pd_rst_owr_out", 64'(owr_out), 64'd0);
        check("pd_rst_state_idle", 64'(dut.r_state), 64'(StIdle));
        check("pd_rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        cycles(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1, "time limit");
    end

endmodule
